// File: rtl/cpu_wb_bus_arbiter.sv
// Two-master / one-slave Wishbone B4 pipelined arbiter sharing the CPU memory port
// between instruction fetch (M0, read-only) and load/store (M1), round-robin per CYC.
module cpu_wb_bus_arbiter #(
  parameter int WISHBONE_ADDR_WIDTH = 32,
  parameter int WISHBONE_BUS_WIDTH  = 32,
  parameter int MAX_OUTSTANDING     = 4
) (
  input  logic                              CLK_I,
  input  logic                              RST_I,
  // Fetch master (M0)
  input  logic                              M0_CYC_I,
  input  logic                              M0_STB_I,
  input  logic [WISHBONE_ADDR_WIDTH-1:0]    M0_ADR_I,
  output logic [WISHBONE_BUS_WIDTH-1:0]     M0_DAT_O,
  output logic                              M0_ACK_O,
  output logic                              M0_ERR_O,
  output logic                              M0_STALL_O,
  // Load/store master (M1)
  input  logic                              M1_CYC_I,
  input  logic                              M1_STB_I,
  input  logic [WISHBONE_ADDR_WIDTH-1:0]    M1_ADR_I,
  input  logic                              M1_WE_I,
  input  logic [WISHBONE_BUS_WIDTH/8-1:0]   M1_SEL_I,
  input  logic [WISHBONE_BUS_WIDTH-1:0]     M1_DAT_I,
  output logic [WISHBONE_BUS_WIDTH-1:0]     M1_DAT_O,
  output logic                              M1_ACK_O,
  output logic                              M1_ERR_O,
  output logic                              M1_STALL_O,
  // Slave port
  output logic                              S_CYC_O,
  output logic                              S_STB_O,
  output logic                              S_WE_O,
  output logic [WISHBONE_ADDR_WIDTH-1:0]    S_ADR_O,
  output logic [WISHBONE_BUS_WIDTH/8-1:0]   S_SEL_O,
  output logic [WISHBONE_BUS_WIDTH-1:0]     S_DAT_O,
  input  logic [WISHBONE_BUS_WIDTH-1:0]     S_DAT_I,
  input  logic                              S_ACK_I,
  input  logic                              S_ERR_I,
  input  logic                              S_STALL_I
);

  localparam int SelWidth = WISHBONE_BUS_WIDTH / 8;
  localparam int CntWidth = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_M0 = 2'd1,
    GNT_M1 = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 lastGnt_q, lastGnt_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;

  logic gntM0, gntM1, full, cntNonZero, issue, retire, stbSel;

  assign gntM0      = (state_q == GNT_M0);
  assign gntM1      = (state_q == GNT_M1);
  assign cntNonZero = (cnt_q != '0);
  assign full       = (cnt_q == CntWidth'(MAX_OUTSTANDING));
  assign issue      = S_STB_O & ~S_STALL_I;
  assign retire     = (S_ACK_I | S_ERR_I) & cntNonZero;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q   <= IDLE;
      lastGnt_q <= 1'b1;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      lastGnt_q <= lastGnt_d;
      cnt_q     <= cnt_d;
    end
  end

  // Grant only changes once the owner drops CYC; leaving a grant abandons its in-flight requests.
  always_comb begin
    state_d   = state_q;
    lastGnt_d = lastGnt_q;
    cnt_d     = cnt_q;
    if (issue && !retire) begin
      cnt_d = cnt_q + CntWidth'(1);
    end else if (!issue && retire) begin
      cnt_d = cnt_q - CntWidth'(1);
    end
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (M0_CYC_I && M1_CYC_I) begin
          state_d = lastGnt_q ? GNT_M0 : GNT_M1;
        end else if (M0_CYC_I) begin
          state_d = GNT_M0;
        end else if (M1_CYC_I) begin
          state_d = GNT_M1;
        end
      end
      GNT_M0: begin
        if (!M0_CYC_I) begin
          cnt_d   = '0;
          state_d = M1_CYC_I ? GNT_M1 : IDLE;
        end
      end
      GNT_M1: begin
        if (!M1_CYC_I) begin
          cnt_d   = '0;
          state_d = M0_CYC_I ? GNT_M0 : IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    if (state_d == GNT_M0) begin
      lastGnt_d = 1'b0;
    end else if (state_d == GNT_M1) begin
      lastGnt_d = 1'b1;
    end
  end

  // Slave-side mux; M0 never writes, so it presents a full-width read.
  always_comb begin
    S_CYC_O = 1'b0;
    stbSel  = 1'b0;
    S_WE_O  = 1'b0;
    S_ADR_O = '0;
    S_SEL_O = '0;
    S_DAT_O = '0;
    if (gntM0) begin
      S_CYC_O = M0_CYC_I;
      stbSel  = M0_STB_I;
      S_ADR_O = M0_ADR_I;
      S_SEL_O = {SelWidth{1'b1}};
    end else if (gntM1) begin
      S_CYC_O = M1_CYC_I;
      stbSel  = M1_STB_I;
      S_WE_O  = M1_WE_I;
      S_ADR_O = M1_ADR_I;
      S_SEL_O = M1_SEL_I;
      S_DAT_O = M1_DAT_I;
    end
  end

  assign S_STB_O    = stbSel & ~full;

  assign M0_DAT_O   = S_DAT_I;
  assign M1_DAT_O   = S_DAT_I;
  assign M0_STALL_O = gntM0 ? (S_STALL_I | full) : 1'b1;
  assign M1_STALL_O = gntM1 ? (S_STALL_I | full) : 1'b1;
  assign M0_ACK_O   = S_ACK_I & gntM0 & cntNonZero;
  assign M1_ACK_O   = S_ACK_I & gntM1 & cntNonZero;
  assign M0_ERR_O   = S_ERR_I & gntM0 & cntNonZero;
  assign M1_ERR_O   = S_ERR_I & gntM1 & cntNonZero;

endmodule

// File: tb/tb_cpu_wb_bus_arbiter.sv
// Directed bench for cpu_wb_bus_arbiter: reset, fetch burst, round-robin,
// outstanding limit, issue+ack overlap, abort, stall and error return.
module tb_cpu_wb_bus_arbiter;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic        M0_CYC_I, M0_STB_I;
  logic [31:0] M0_ADR_I;
  logic [31:0] M0_DAT_O;
  logic        M0_ACK_O, M0_ERR_O, M0_STALL_O;
  logic        M1_CYC_I, M1_STB_I, M1_WE_I;
  logic [31:0] M1_ADR_I, M1_DAT_I;
  logic [3:0]  M1_SEL_I;
  logic [31:0] M1_DAT_O;
  logic        M1_ACK_O, M1_ERR_O, M1_STALL_O;
  logic        S_CYC_O, S_STB_O, S_WE_O;
  logic [31:0] S_ADR_O, S_DAT_O;
  logic [3:0]  S_SEL_O;
  logic [31:0] S_DAT_I;
  logic        S_ACK_I, S_ERR_I, S_STALL_I;

  int testCount = 0;
  int failCount = 0;

  cpu_wb_bus_arbiter #(
    .WISHBONE_ADDR_WIDTH(32),
    .WISHBONE_BUS_WIDTH(32),
    .MAX_OUTSTANDING(4)
  ) dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .M0_CYC_I(M0_CYC_I), .M0_STB_I(M0_STB_I), .M0_ADR_I(M0_ADR_I),
    .M0_DAT_O(M0_DAT_O), .M0_ACK_O(M0_ACK_O), .M0_ERR_O(M0_ERR_O), .M0_STALL_O(M0_STALL_O),
    .M1_CYC_I(M1_CYC_I), .M1_STB_I(M1_STB_I), .M1_ADR_I(M1_ADR_I),
    .M1_WE_I(M1_WE_I), .M1_SEL_I(M1_SEL_I), .M1_DAT_I(M1_DAT_I),
    .M1_DAT_O(M1_DAT_O), .M1_ACK_O(M1_ACK_O), .M1_ERR_O(M1_ERR_O), .M1_STALL_O(M1_STALL_O),
    .S_CYC_O(S_CYC_O), .S_STB_O(S_STB_O), .S_WE_O(S_WE_O), .S_ADR_O(S_ADR_O),
    .S_SEL_O(S_SEL_O), .S_DAT_O(S_DAT_O), .S_DAT_I(S_DAT_I),
    .S_ACK_I(S_ACK_I), .S_ERR_I(S_ERR_I), .S_STALL_I(S_STALL_I)
  );

  always #5 CLK_I = ~CLK_I;

  // Move to just after the next rising edge and drive the slave response for that cycle.
  task automatic applyStimulus(input logic ack, input logic err, input logic stall,
                               input logic [31:0] dat);
    @(posedge CLK_I);
    #1;
    S_ACK_I   = ack;
    S_ERR_I   = err;
    S_STALL_I = stall;
    S_DAT_I   = dat;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    RST_I = 1'b1;
    M0_CYC_I = 1'b1; M0_STB_I = 1'b0; M0_ADR_I = '0;
    M1_CYC_I = 1'b1; M1_STB_I = 1'b0; M1_ADR_I = '0;
    M1_WE_I = 1'b0; M1_SEL_I = '0; M1_DAT_I = '0;
    S_ACK_I = 1'b0; S_ERR_I = 1'b0; S_STALL_I = 1'b0; S_DAT_I = '0;

    // Reset held two cycles with both masters requesting and a stray ACK present
    applyStimulus(1'b1, 1'b0, 1'b0, 32'hDEAD);
    settle();
    checkOutput("rst_s_cyc", S_CYC_O, 0);
    checkOutput("rst_s_stb", S_STB_O, 0);
    checkOutput("rst_s_adr", S_ADR_O, 0);
    checkOutput("rst_s_sel", S_SEL_O, 0);
    checkOutput("rst_m0_stall", M0_STALL_O, 1);
    checkOutput("rst_m1_stall", M1_STALL_O, 1);
    checkOutput("rst_m0_ack", M0_ACK_O, 0);
    checkOutput("rst_m1_ack", M1_ACK_O, 0);
    checkOutput("rst_m0_dat", M0_DAT_O, 32'hDEAD);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    RST_I = 1'b0;
    settle();
    checkOutput("rst_idle_cyc", S_CYC_O, 0);
    checkOutput("rst_idle_m0_stall", M0_STALL_O, 1);

    // Tie after reset goes to M0; fetch burst of three reads
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    M1_CYC_I = 1'b0; M0_STB_I = 1'b1; M0_ADR_I = 32'h100;
    settle();
    checkOutput("tie_m0_stall", M0_STALL_O, 0);
    checkOutput("tie_m1_stall", M1_STALL_O, 1);
    checkOutput("burst_s_cyc", S_CYC_O, 1);
    checkOutput("burst_s_stb0", S_STB_O, 1);
    checkOutput("burst_s_adr0", S_ADR_O, 32'h100);
    checkOutput("burst_s_we", S_WE_O, 0);
    checkOutput("burst_s_sel", S_SEL_O, 4'hF);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'hA);
    M0_ADR_I = 32'h104;
    settle();
    checkOutput("burst_s_adr1", S_ADR_O, 32'h104);
    checkOutput("burst_ack0", M0_ACK_O, 1);
    checkOutput("burst_dat0", M0_DAT_O, 32'hA);
    checkOutput("burst_m1_ack0", M1_ACK_O, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'hB);
    M0_ADR_I = 32'h108;
    settle();
    checkOutput("burst_s_adr2", S_ADR_O, 32'h108);
    checkOutput("burst_ack1", M0_ACK_O, 1);
    checkOutput("burst_dat1", M0_DAT_O, 32'hB);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'hC);
    M0_STB_I = 1'b0;
    settle();
    checkOutput("burst_s_stb_off", S_STB_O, 0);
    checkOutput("burst_ack2", M0_ACK_O, 1);
    checkOutput("burst_dat2", M0_DAT_O, 32'hC);
    checkOutput("burst_m1_ack2", M1_ACK_O, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'hD);
    settle();
    checkOutput("burst_spurious_ack", M0_ACK_O, 0);

    // Round-robin: M1 requests while M0 holds the bus
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    M1_CYC_I = 1'b1; M0_STB_I = 1'b1; M0_ADR_I = 32'h110;
    settle();
    checkOutput("rr_hold_m1_stall", M1_STALL_O, 1);
    checkOutput("rr_hold_m0_stall", M0_STALL_O, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h1);
    M0_ADR_I = 32'h114;
    settle();
    checkOutput("rr_m0_ack0", M0_ACK_O, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h2);
    M0_STB_I = 1'b0;
    settle();
    checkOutput("rr_m0_ack1", M0_ACK_O, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    M0_CYC_I = 1'b0;
    settle();
    checkOutput("rr_m0_drop_s_cyc", S_CYC_O, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    M0_CYC_I = 1'b1;
    M1_STB_I = 1'b1; M1_WE_I = 1'b1; M1_ADR_I = 32'h200; M1_DAT_I = 32'h11; M1_SEL_I = 4'h3;
    settle();
    checkOutput("rr_m1_stall", M1_STALL_O, 0);
    checkOutput("rr_m0_waiting_stall", M0_STALL_O, 1);
    checkOutput("rr_m1_s_we", S_WE_O, 1);
    checkOutput("rr_m1_s_adr", S_ADR_O, 32'h200);
    checkOutput("rr_m1_s_dat", S_DAT_O, 32'h11);
    checkOutput("rr_m1_s_sel", S_SEL_O, 4'h3);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    M1_ADR_I = 32'h204;
    settle();
    checkOutput("rr_m1_ack0", M1_ACK_O, 1);
    checkOutput("rr_m0_no_ack", M0_ACK_O, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    M1_STB_I = 1'b0;
    settle();
    checkOutput("rr_m1_ack1", M1_ACK_O, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    M1_CYC_I = 1'b0;
    settle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    M1_CYC_I = 1'b1;
    settle();
    checkOutput("rr_m0_again_stall", M0_STALL_O, 0);
    checkOutput("rr_m0_again_m1_stall", M1_STALL_O, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    M0_CYC_I = 1'b0;
    settle();

    // Outstanding limit: M1 keeps strobing with no ACKs
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    M1_STB_I = 1'b1; M1_ADR_I = 32'h300;
    settle();
    checkOutput("lim_m1_stall", M1_STALL_O, 0);
    checkOutput("lim_stb1", S_STB_O, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      settle();
      checkOutput("lim_stb_accept", S_STB_O, 1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("lim_full_stb", S_STB_O, 0);
    checkOutput("lim_full_stall", M1_STALL_O, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("lim_full_ack_stb", S_STB_O, 0);
    checkOutput("lim_full_ack_stall", M1_STALL_O, 1);
    checkOutput("lim_full_ack_fwd", M1_ACK_O, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("lim_fifth_stb", S_STB_O, 1);
    checkOutput("lim_fifth_stall", M1_STALL_O, 0);

    // Drain to two outstanding, then issue and retire in the same cycle
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    M1_STB_I = 1'b0;
    settle();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    settle();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    M1_STB_I = 1'b1;
    settle();
    checkOutput("ovl_stb", S_STB_O, 1);
    checkOutput("ovl_ack", M1_ACK_O, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    M1_STB_I = 1'b0;
    settle();
    checkOutput("ovl_drain_ack0", M1_ACK_O, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("ovl_drain_ack1", M1_ACK_O, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("ovl_drain_empty", M1_ACK_O, 0);

    // Abort: M1 leaves with two outstanding while M0 waits
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    M1_STB_I = 1'b1; M0_CYC_I = 1'b1;
    settle();
    checkOutput("abt_m0_wait_stall", M0_STALL_O, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    M1_CYC_I = 1'b0; M1_STB_I = 1'b0;
    settle();
    checkOutput("abt_s_cyc_drop", S_CYC_O, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("abt_m0_granted", M0_STALL_O, 0);
    checkOutput("abt_m0_s_cyc", S_CYC_O, 1);
    checkOutput("abt_late_ack_m0", M0_ACK_O, 0);
    checkOutput("abt_late_ack_m1", M1_ACK_O, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("abt_late_ack2_m0", M0_ACK_O, 0);
    checkOutput("abt_late_ack2_m1", M1_ACK_O, 0);

    // Slave stall blocks acceptance, so a later ACK has nothing to match
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
    M0_STB_I = 1'b1; M0_ADR_I = 32'h400;
    settle();
    checkOutput("stl_m0_stall", M0_STALL_O, 1);
    checkOutput("stl_s_stb", S_STB_O, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    M0_STB_I = 1'b0;
    settle();
    checkOutput("stl_no_ack", M0_ACK_O, 0);

    // Error response routed to the owner exactly once
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    M0_STB_I = 1'b1;
    settle();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    M0_STB_I = 1'b0;
    settle();
    checkOutput("err_m0", M0_ERR_O, 1);
    checkOutput("err_m0_ack", M0_ACK_O, 0);
    checkOutput("err_m1", M1_ERR_O, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    settle();
    checkOutput("err_m0_empty", M0_ERR_O, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/cpu_wb_bus_arbiter.md
# cpu_wb_bus_arbiter

Two-master, one-slave Wishbone B4 pipelined arbiter that shares the CPU's single memory port between the instruction-fetch master (M0) and the load/store data master (M1). Sits between the CPU's fetch and data Wishbone masters and the memory/interconnect slave. Performs round-robin arbitration at cycle (CYC) granularity, tracks outstanding pipelined requests, and routes ACK/ERR/read data back to the owning master.

## Interface
- WISHBONE_ADDR_WIDTH, 32, address width
- WISHBONE_BUS_WIDTH, 32, data width; SEL width = WISHBONE_BUS_WIDTH/8
- MAX_OUTSTANDING, 4, maximum accepted-but-unacknowledged requests (≥1)

Ports (Mx = M0/M1; M0 has no WE/SEL/DAT_O and is read-only):
- CLK_I  in  1  single clock, rising edge
- RST_I  in  1  synchronous, active-high reset
- Mx_CYC_I, Mx_STB_I  in  1  master cycle/strobe
- Mx_ADR_I  in  ADDR  master address
- M1_WE_I  in  1; M1_SEL_I  in  BUS/8; M1_DAT_I  in  BUS  write data
- Mx_DAT_O  out  BUS  read data (slave DAT_I, broadcast)
- Mx_ACK_O, Mx_ERR_O, Mx_STALL_O  out  1
- S_CYC_O, S_STB_O, S_WE_O  out  1; S_ADR_O  out  ADDR; S_SEL_O  out  BUS/8; S_DAT_O  out  BUS
- S_DAT_I  in  BUS; S_ACK_I, S_ERR_I, S_STALL_I  in  1

## Operation
- States: IDLE, GNT_M0, GNT_M1 (registered). last_gnt bit (registered) records the most recent grant.
- IDLE: one requester (CYC high) → grant it; both → grant the one ≠ last_gnt; none → stay.
- GNT_Mx: hold while Mx_CYC_I=1. When Mx_CYC_I=0: other master CYC=1 → GNT_other directly; else → IDLE.
- Granted master is muxed to slave: S_CYC_O=Mx_CYC_I, S_STB_O=Mx_STB_I & ~full, S_ADR/WE/SEL/DAT from Mx (WE=0, SEL=all-ones, DAT=0 for M0). In IDLE all S_* outputs = 0.
- Mx_STALL_O: granted → S_STALL_I | full; not granted → 1.
- Outstanding count cnt (width clog2(MAX_OUTSTANDING+1)): +1 on S_STB_O & ~S_STALL_I; −1 on (S_ACK_I|S_ERR_I) & cnt≠0; both same cycle → unchanged. full = (cnt==MAX_OUTSTANDING).
- Mx_ACK_O = S_ACK_I & granted & cnt≠0; Mx_ERR_O likewise with S_ERR_I. ACK/ERR while cnt==0 or IDLE is dropped. Non-granted master ACK/ERR always 0.
- Granted master drops CYC with cnt>0: cycle aborted; cnt cleared to 0 next cycle; subsequent slave ACKs dropped.
- Arbitration never changes grant while granted CYC is high, regardless of other requester.

## Timing
- Reset (RST_I sampled high): state=IDLE, last_gnt=M1 (so M0 wins first tie), cnt=0. All S_* outputs 0; Mx_ACK_O=Mx_ERR_O=0; Mx_STALL_O=1; Mx_DAT_O follows S_DAT_I.
- Reset mid-transaction: next cycle IDLE, cnt=0, in-flight ACKs dropped.
- Grant latency: CYC rising at edge N (state IDLE) → granted after edge N+1; first S_STB_O in cycle N+1. Master sees STALL=1 in cycle N.
- Handoff: granted CYC low at edge N, other CYC high → other granted in cycle N+1, zero idle cycles.
- Slave-side signals are combinational from granted master once in GNT_Mx; ACK/STALL/DAT return is combinational (no added latency).
- Full: with cnt=MAX_OUTSTANDING, S_STB_O=0 and STALL=1; simultaneous ACK allows no new issue that cycle (full evaluated on registered cnt).

## Test plan
- Reset: assert RST_I 2 cycles with both CYC high → all S_* = 0, STALL both = 1; release → M0 granted next cycle (last_gnt=M1).
- Single fetch burst: M0 issues 3 pipelined reads to 0x100/0x104/0x108, slave ACKs 1 cycle later with 0xA,0xB,0xC → M0_ACK_O three pulses with matching DAT, cnt returns 0, M1 ACK never asserts.
- Round-robin: both CYC held high, each drops after 2 ACKs → grants alternate M0,M1,M0,M1 with direct handoff, no IDLE cycle.
- Outstanding limit: MAX_OUTSTANDING=4, slave never ACKs, M1 strobes 6 writes → exactly 4 accepted, S_STB_O low and M1_STALL_O high after 4th; one ACK → 5th accepted.
- Simultaneous issue+ACK: cnt=2, STB accepted and ACK same cycle → cnt stays 2.
- Abort: M1 drops CYC with cnt=2, slave ACKs 2 cycles later → cnt=0, no ACK forwarded to either master, M0 (waiting) granted next cycle.
